// File: rtl/mult8_seq_pkg.sv
// Shared types and constants for the 8x8 sequential multiplier controller.
package mult8_seq_pkg;

  localparam int NIB_W  = 4;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] step_t;

  localparam logic [3:0] SHIFT_S0 = 4'd0;
  localparam logic [3:0] SHIFT_S1 = 4'd4;
  localparam logic [3:0] SHIFT_S2 = 4'd4;
  localparam logic [3:0] SHIFT_S3 = 4'd8;

  // Left shift applied to the core's partial product for a given step.
  function automatic logic [3:0] step_shift(input step_t s);
    logic [3:0] sh;
    case (s)
      2'd0:    sh = SHIFT_S0;
      2'd1:    sh = SHIFT_S1;
      2'd2:    sh = SHIFT_S2;
      default: sh = SHIFT_S3;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_nibble_mult4.sv
// Combinational 4x4 -> 8-bit unsigned array multiplier: AND partial products
// reduced by rows of ripple adders (first cell of each row is a half adder).
module nibble_mult4
  import mult8_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   a_i,
  input  logic [NIB_W-1:0]   b_i,
  output logic [2*NIB_W-1:0] p_o
);

  // One full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  logic [NIB_W-1:0] row_s;
  logic             row_c;
  logic [NIB_W-1:0] row_x;
  logic             carry;
  logic [1:0]       fa_r;

  // Accumulate partial-product rows; each row retires one low product bit.
  always_comb begin
    p_o   = '0;
    row_s = a_i & {NIB_W{b_i[0]}};
    row_c = 1'b0;
    row_x = '0;
    carry = 1'b0;
    fa_r  = '0;
    p_o[0] = row_s[0];
    for (int i = 1; i < NIB_W; i++) begin
      row_x = {row_c, row_s[NIB_W-1:1]};
      carry = 1'b0;
      for (int j = 0; j < NIB_W; j++) begin
        fa_r     = full_add(row_x[j], a_i[j] & b_i[i], carry);
        row_s[j] = fa_r[0];
        carry    = fa_r[1];
      end
      row_c  = carry;
      p_o[i] = row_s[0];
    end
    p_o[2*NIB_W-1:NIB_W] = {row_c, row_s[NIB_W-1:1]};
  end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// 8x8 -> 16-bit multiplier that time-multiplexes one 4x4 core over four steps.
// Optional build macro: SIGNED_MULT_EN (two's complement operands, sign applied
// to the magnitude product on entry to DONE).
module mult8_seq_ctrl
  import mult8_seq_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_a,
  input  logic [7:0]        in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              busy
);

  localparam logic [1:0] WAIT_LAST = 2'(WAIT_STATES);

  state_e            state_q, state_d;
  step_t             step_q, step_d;
  logic [1:0]        wait_q, wait_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [7:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [PROD_W-1:0] out_p_q, out_p_d;
  logic              out_valid_q, out_valid_d;

  logic [NIB_W-1:0]   core_a_nib, core_b_nib;
  logic [2*NIB_W-1:0] core_p;
  logic [PROD_W-1:0]  step_sum, final_p;
  logic [7:0]         accept_a, accept_b;

`ifdef SIGNED_MULT_EN
  logic sign_q, sign_d;

  function automatic logic [7:0] mag8(input logic [7:0] x);
    return x[7] ? 8'(~x + 8'd1) : x;
  endfunction

  assign accept_a = mag8(in_a);
  assign accept_b = mag8(in_b);
  assign final_p  = (sign_q && (step_sum != '0)) ? 16'(16'd0 - step_sum) : step_sum;
`else
  assign accept_a = in_a;
  assign accept_b = in_b;
  assign final_p  = step_sum;
`endif

  // Route operand nibbles to the core; stable for the whole step.
  always_comb begin
    core_a_nib = step_q[0] ? op_a_q[7:4] : op_a_q[3:0];
    core_b_nib = step_q[1] ? op_b_q[7:4] : op_b_q[3:0];
  end

  nibble_mult4 u_core (
    .a_i (core_a_nib),
    .b_i (core_b_nib),
    .p_o (core_p)
  );

  assign step_sum  = acc_q + (16'(core_p) << step_shift(step_q));
  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

  // Next-state and datapath control for IDLE -> MUL -> DONE.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    wait_d      = wait_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
`ifdef SIGNED_MULT_EN
    sign_d      = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_a_d  = accept_a;
          op_b_d  = accept_b;
`ifdef SIGNED_MULT_EN
          sign_d  = in_a[7] ^ in_b[7];
`endif
          acc_d   = '0;
          step_d  = '0;
          wait_d  = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (wait_q == WAIT_LAST) begin
          acc_d  = step_sum;
          wait_d = '0;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            out_p_d     = final_p;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with asynchronous abort to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      wait_q      <= '0;
      acc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef SIGNED_MULT_EN
      sign_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      wait_q      <= wait_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
`ifdef SIGNED_MULT_EN
      sign_q      <= sign_d;
`endif
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed bench for mult8_seq_ctrl (WAIT_STATES=0 and WAIT_STATES=2 instances).
module tb_mult8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_p;

  logic        w_in_valid, w_out_ready;
  logic [7:0]  w_in_a, w_in_b;
  logic        w_in_ready, w_out_valid, w_busy;
  logic [15:0] w_out_p;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  mult8_seq_ctrl #(.WAIT_STATES(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .busy(busy)
  );

  mult8_seq_ctrl #(.WAIT_STATES(2)) dut_ws2 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_p(w_out_p), .busy(w_busy)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // One multiply on the WAIT_STATES=0 instance; latency counted from the accepting edge.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp);
    int n;
    @(negedge clk);
    check_val({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0; in_a = ~a; in_b = ~b;
    check_val({tag, "_busy"}, 16'(busy), 16'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_latency"}, 16'(n), 16'd4);
    check_val({tag, "_out_p"}, out_p, exp);
    $display("op %s: 0x%02h * 0x%02h -> 0x%04h (expected 0x%04h) after %0d edges",
             tag, a, b, out_p, exp, n);
    if (out_ready) begin
      @(negedge clk);
      check_val({tag, "_pulse"}, 16'(out_valid), 16'd0);
      check_val({tag, "_idle_ready"}, 16'(in_ready), 16'd1);
    end
  endtask

  initial begin
    logic [15:0] bp_exp, ws_exp;
    logic [7:0]  ws_a_mag, ws_b_mag;
    logic [3:0]  exp_an, exp_bn;
    int          stp;

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_out_valid", 16'(out_valid), 16'd0);
    check_val("rst_out_p", out_p, 16'h0000);
    check_val("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;

    run_op("basic", 8'h12, 8'h34, 16'h03A8);
`ifdef SIGNED_MULT_EN
    run_op("s_80x80", 8'h80, 8'h80, 16'h4000);
    run_op("s_FFx02", 8'hFF, 8'h02, 16'hFFFE);
    run_op("s_00x80", 8'h00, 8'h80, 16'h0000);
    bp_exp = 16'hE002;
    ws_exp = 16'hFFFE; ws_a_mag = 8'h01; ws_b_mag = 8'h02;
`else
    run_op("FFxFF", 8'hFF, 8'hFF, 16'hFE01);
    run_op("00xFF", 8'h00, 8'hFF, 16'h0000);
    run_op("0Fx F0", 8'h0F, 8'hF0, 16'h0E10);
    bp_exp = 16'h3A02;
    ws_exp = 16'h01FE; ws_a_mag = 8'hFF; ws_b_mag = 8'h02;
`endif

    // Backpressure: consumer stalls for 10 cycles after completion.
    out_ready = 1'b0;
    run_op("bp", 8'hA5, 8'h5A, bp_exp);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp_hold_valid", 16'(out_valid), 16'd1);
      check_val("bp_hold_p", out_p, bp_exp);
      check_val("bp_hold_in_ready", 16'(in_ready), 16'd0);
      check_val("bp_hold_busy", 16'(busy), 16'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_release_valid", 16'(out_valid), 16'd0);
    check_val("bp_release_in_ready", 16'(in_ready), 16'd1);
    check_val("bp_release_p_kept", out_p, bp_exp);
    $display("backpressure: held 10 cycles, released to idle");

    // Reset during step 2 of 0xAB*0xCD.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'hAB; in_b = 8'hCD;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("abort_out_valid", 16'(out_valid), 16'd0);
    check_val("abort_out_p", out_p, 16'h0000);
    check_val("abort_busy", 16'(busy), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("abort_no_valid", 16'(out_valid), 16'd0);
    end
    rst = 1'b0;
    $display("abort: reset during step 2, result discarded");
    run_op("after_abort", 8'h03, 8'h05, 16'h000F);

    // WAIT_STATES=2 instance: 3 cycles per step, 12-edge latency.
    @(negedge clk);
    check_val("ws2_in_ready", 16'(w_in_ready), 16'd1);
    w_in_valid = 1'b1; w_in_a = 8'hFF; w_in_b = 8'h02;
    @(negedge clk);
    w_in_valid = 1'b0; w_in_a = 8'h00; w_in_b = 8'h00;
    for (int k = 0; k < 12; k++) begin
      stp    = k / 3;
      exp_an = stp[0] ? ws_a_mag[7:4] : ws_a_mag[3:0];
      exp_bn = stp[1] ? ws_b_mag[7:4] : ws_b_mag[3:0];
      check_val("ws2_core_a", 16'(dut_ws2.core_a_nib), 16'(exp_an));
      check_val("ws2_core_b", 16'(dut_ws2.core_b_nib), 16'(exp_bn));
      check_val("ws2_not_yet", 16'(w_out_valid), 16'd0);
      @(negedge clk);
    end
    check_val("ws2_valid_at_12", 16'(w_out_valid), 16'd1);
    check_val("ws2_out_p", w_out_p, ws_exp);
    $display("op ws2: 0xFF * 0x02 -> 0x%04h (expected 0x%04h) after 12 edges", w_out_p, ws_exp);
    @(negedge clk);
    check_val("ws2_pulse", 16'(w_out_valid), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/mult8_seq_ctrl.md
Name: mult8_seq_ctrl

Overview:
Sequencing controller that computes an 8x8 -> 16-bit product by time-multiplexing one combinational 4x4 array multiplier core over four partial-product steps. Each step shifts the core's partial product and adds it into a 16-bit accumulator. Operands arrive and results leave over valid/ready handshakes. It sits between a lab test harness or operand source and a downstream consumer, letting the small core serve wider operands.

Parameters:
WAIT_STATES, 0, extra settle cycles per step before the core output is sampled (multicycle core path); legal 0..3.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  controller can accept operands
in_a  input  8  multiplicand
in_b  input  8  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
out_p  output  16  product
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, step=0, wait count=0, acc=0, out_valid=0, out_p=0, busy=0, in_ready=1 once rst deasserts.
- States: IDLE -> MUL -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid&&in_ready: latch in_a/in_b into op_a/op_b, clear acc, set step=0, wait count=0, go to MUL.
  - in_valid without acceptance has no effect.
- MUL:
  - in_ready=0.
  - Core inputs are selected by step:
    - step0: a[3:0]*b[3:0], shift 0
    - step1: a[7:4]*b[3:0], shift 4
    - step2: a[3:0]*b[7:4], shift 4
    - step3: a[7:4]*b[7:4], shift 8
  - The core nibble inputs are held stable for the whole step.
  - Each step lasts 1+WAIT_STATES cycles.
  - On the last cycle of a step: acc <= acc + (core_p << shift), truncated to 16 bits (the true sum never overflows), and step increments.
  - On the last cycle of step3: acc update, out_p <= final sum, out_valid <= 1, go to DONE.
- Latency: out_valid rises 4*(1+WAIT_STATES) clock edges after the accepting edge; with WAIT_STATES=0 that is 4 edges.
- DONE:
  - out_valid=1; out_p is held stable until handshake.
  - On out_valid&&out_ready: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept.
  - Throughput with WAIT_STATES=0: one product per 6 cycles minimum.
- out_p keeps its last value after handshake until the next completion.
- Reset mid-operation: immediate abort to the reset values above; the in-flight result is discarded and nothing is emitted.
- Operand inputs change in MUL/DONE: ignored, because latched copies are used.

Optional Feature:
SIGNED_MULT_EN
- Defined:
  - in_a/in_b are two's complement.
  - On accept, op_a/op_b latch the magnitudes (8-bit unsigned; 0x80 -> 128) and a sign flag = a[7]^b[7].
  - Result is negated if the sign flag is set and the magnitude is nonzero.
  - Negation is applied in the DONE-entry cycle with no extra latency.
- Not defined: unsigned operands only; no sign logic is synthesized.

Decomposition:
- Package mult8_seq_pkg holds:
  - state enum (IDLE, MUL, DONE)
  - 2-bit step type
  - shift-amount constants per step (0, 4, 4, 8)
  - nibble width 4 and product width 16 constants
- One sub-module, nibble_mult4: combinational 4x4 -> 8-bit unsigned array multiplier built from AND partial products plus half/full adder rows.
  - Instantiated once.
  - Its inputs are muxed by step.

Test Plan:
- Basic: accept in_a=0x12, in_b=0x34, out_ready=1 -> out_valid exactly 4 edges later, out_p=0x03A8, single-cycle pulse.
- Corners: 0xFF*0xFF -> 0xFE01; 0x00*0xFF -> 0x0000; 0x0F*0xF0 -> 0x0E10.
- Backpressure: hold out_ready=0 for 10 cycles after completion -> out_p and out_valid stable, in_ready=0, busy=1; release -> IDLE next edge, in_ready=1.
- Reset mid-op: assert rst during step2 of 0xAB*0xCD -> outputs return to reset values immediately, no out_valid; next op 0x03*0x05 -> 0x000F.
- WAIT_STATES=2: 0xFF*0x02 -> out_p=0x01FE with latency 12 edges; core nibble inputs constant within each step.
- SIGNED_MULT_EN defined: 0x80*0x80 -> 0x4000; 0xFF*0x02 -> 0xFFFE; 0x00*0x80 -> 0x0000.
